// File: rtl/sik_mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : sik_mem_arbiter_if
// Description : Fetch, data and memory-side bundle of the Sik memory arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sik_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_ack, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  // Requesters plus memory side
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_ack, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

`default_nettype wire

// File: rtl/sik_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : sik_mem_arbiter
// Description : Round-robin arbiter sharing one fixed-latency memory between
//               the fetch (read-only) and data (load/store) ports.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sik_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  wire logic         clk,
  input  wire logic         reset,
  sik_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] c_cnt_init = 3'(MEM_LAT - 1);

  state_t            r_state;
  logic              r_last_d;
  logic              r_cmd_d;
  logic              r_cmd_we;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_f_gnt;
  logic              r_d_gnt;
  logic              r_f_rvalid;
  logic              r_d_ack;
  logic              r_m_en;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;

  logic              w_any;
  logic              w_win_d;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // D wins a tie only when F was granted last
  assign w_any   = bus.f_req | bus.d_req;
  assign w_win_d = bus.d_req & (~bus.f_req | ~r_last_d);
  assign w_we    = w_win_d & bus.d_we;
  assign w_addr  = w_win_d ? bus.d_addr  : bus.f_addr;
  assign w_wdata = w_win_d ? bus.d_wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last_d   <= 1'b0;
      r_cmd_d    <= 1'b0;
      r_cmd_we   <= 1'b0;
      r_cnt      <= 3'd0;
      r_rdata    <= '0;
      r_f_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_f_rvalid <= 1'b0;
      r_d_ack    <= 1'b0;
      r_m_en     <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
    end else begin
      r_f_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_f_rvalid <= 1'b0;
      r_d_ack    <= 1'b0;
      r_m_en     <= 1'b0;
      r_m_we     <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_any) begin
            // The memory command registers double as the held command
            r_state   <= S_ISSUE;
            r_cmd_d   <= w_win_d;
            r_cmd_we  <= w_we;
            r_last_d  <= w_win_d;
            r_f_gnt   <= ~w_win_d;
            r_d_gnt   <= w_win_d;
            r_m_en    <= 1'b1;
            r_m_we    <= w_we;
            r_m_addr  <= w_addr;
            r_m_wdata <= w_wdata;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (r_cmd_we) begin
            r_state <= S_RESP;
            r_d_ack <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= c_cnt_init;
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state    <= S_RESP;
            r_rdata    <= bus.m_rdata;
            r_f_rvalid <= ~r_cmd_d;
            r_d_ack    <= r_cmd_d;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.f_gnt    = r_f_gnt;
  assign bus.f_rvalid = r_f_rvalid;
  assign bus.f_rdata  = r_rdata;
  assign bus.d_gnt    = r_d_gnt;
  assign bus.d_ack    = r_d_ack;
  assign bus.d_rdata  = r_rdata;
  assign bus.m_en     = r_m_en;
  assign bus.m_we     = r_m_we;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_wdata  = r_m_wdata;

endmodule

`default_nettype wire

// File: tb/tb_sik_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_sik_mem_arbiter
// Description : Self-checking bench; three arbiters (MEM_LAT 2, 1, 4) share
//               the same requester stimulus, each with its own memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sik_mem_arbiter;

  localparam int c_n_rand = 1500;
  localparam int c_lat0   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_we;
  logic [15:0] f_addr, d_addr, d_wdata;

  logic [2:0]  fg_v, dg_v, fv_v, da_v, men_v, mwe_v;
  logic [15:0] frd_v [3];
  logic [15:0] drd_v [3];
  logic [15:0] maddr_v [3];
  logic [15:0] mwd_v [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Unwritten memory words read back as a function of their address
  function automatic logic [15:0] hashf(input logic [15:0] a);
    return a ^ 16'h8133;
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : g_lat
      localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      sik_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
      bit   [15:0] mem [65536];
      bit          wrn [65536];
      logic [15:0] pipe [4];

      assign bus.f_req   = f_req;
      assign bus.f_addr  = f_addr;
      assign bus.d_req   = d_req;
      assign bus.d_we    = d_we;
      assign bus.d_addr  = d_addr;
      assign bus.d_wdata = d_wdata;
      assign bus.m_rdata = pipe[LAT-1];

      assign fg_v[g]    = bus.f_gnt;
      assign dg_v[g]    = bus.d_gnt;
      assign fv_v[g]    = bus.f_rvalid;
      assign da_v[g]    = bus.d_ack;
      assign men_v[g]   = bus.m_en;
      assign mwe_v[g]   = bus.m_we;
      assign frd_v[g]   = bus.f_rdata;
      assign drd_v[g]   = bus.d_rdata;
      assign maddr_v[g] = bus.m_addr;
      assign mwd_v[g]   = bus.m_wdata;

      always @(posedge clk) begin
        if (bus.m_en && bus.m_we) begin
          mem[bus.m_addr] <= bus.m_wdata;
          wrn[bus.m_addr] <= 1'b1;
        end
        pipe[0] <= (bus.m_en && !bus.m_we)
                   ? (wrn[bus.m_addr] ? mem[bus.m_addr] : hashf(bus.m_addr))
                   : 16'($urandom);
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end

      sik_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
      );
    end
  endgenerate

  typedef struct {
    bit          fr;
    bit          dr;
    bit          dwe;
    logic [15:0] fa;
    logic [15:0] da;
    logic [15:0] dwd;
    bit          exp_d;
    int          exp_cyc;
    bit          chk_rd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // One table entry: drive, hold each req until its gnt, wait for all responses
  task automatic run_vec(input int idx);
    vec_t        v;
    int          first;
    int          rsp;
    bit          fdone, ddone;
    logic [15:0] rd;
    v = vt[idx];
    first = -1; rsp = -1; rd = '0;
    fdone = !v.fr; ddone = !v.dr;
    f_req = v.fr; f_addr = v.fa;
    d_req = v.dr; d_we = v.dwe; d_addr = v.da; d_wdata = v.dwd;
    for (int e = 0; e < 40 && !(fdone && ddone); e++) begin
      tick();
      if (fg_v[0]) begin if (first < 0) first = 0; f_req = 1'b0; end
      if (dg_v[0]) begin if (first < 0) first = 1; d_req = 1'b0; end
      if (fv_v[0]) begin
        fdone = 1'b1;
        if (first == 0 && rsp < 0) begin rsp = e + 1; rd = frd_v[0]; end
      end
      if (da_v[0]) begin
        ddone = 1'b1;
        if (first == 1 && rsp < 0) begin rsp = e + 1; rd = drd_v[0]; end
      end
    end
    chk($sformatf("vec%0d_done", idx), 32'(fdone && ddone), 32'd1);
    chk($sformatf("vec%0d_winner", idx), 32'(first), 32'(v.exp_d));
    chk($sformatf("vec%0d_resp_cycle", idx), 32'(rsp), 32'(v.exp_cyc));
    if (v.chk_rd) chk($sformatf("vec%0d_rdata", idx), 32'(rd), 32'(v.exp_rd));
  endtask

  task automatic rr_test();
    int  gtime [8];
    bit  gport [8];
    int  n;
    do_reset();
    f_req = 1'b1; f_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h00A0;
    n = 0;
    for (int e = 0; e < 80 && n < 8; e++) begin
      tick();
      if (fg_v[0] || dg_v[0]) begin
        gtime[n] = e; gport[n] = dg_v[0]; n++;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    chk("rr_grant_count", 32'(n), 32'd8);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rr_order%0d", i), 32'(gport[i]), 32'((i % 2) == 0));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(gtime[i] - gtime[i-1]), 32'(c_lat0 + 2));
    end
    repeat (8) tick();
  endtask

  task automatic reset_mid_test();
    int nrv;
    do_reset();
    f_req = 1'b1; f_addr = 16'h0010;
    tick();
    chk("rstmid_fgnt", 32'(fg_v[0]), 32'd1);
    f_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rstmid_outputs_zero",
        {fg_v[0], dg_v[0], fv_v[0], da_v[0], men_v[0], mwe_v[0], frd_v[0] | drd_v[0] | maddr_v[0] | mwd_v[0]},
        32'd0);
    reset = 1'b0;
    nrv = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (fv_v[0]) nrv++;
    end
    chk("rstmid_no_rvalid", 32'(nrv), 32'd0);
    f_req = 1'b1; f_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h00A0;
    tick();
    chk("rstmid_tie_grants_d", {30'd0, fg_v[0], dg_v[0]}, 32'b01);
    f_req = 1'b0; d_req = 1'b0;
    repeat (8) tick();
  endtask

  task automatic sweep_test();
    int          cyc [3];
    int          nen [3];
    logic [15:0] rd [3];
    int          lat [3];
    lat[0] = 2; lat[1] = 1; lat[2] = 4;
    for (int g = 0; g < 3; g++) begin cyc[g] = -1; nen[g] = 0; rd[g] = '0; end
    do_reset();
    f_req = 1'b1; f_addr = 16'h9307;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 0) f_req = 1'b0;
      for (int g = 0; g < 3; g++) begin
        if (men_v[g]) nen[g]++;
        if (fv_v[g] && cyc[g] < 0) begin cyc[g] = e + 1; rd[g] = frd_v[g]; end
      end
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("sweep_lat%0d_cycle", lat[g]), 32'(cyc[g]), 32'(lat[g] + 2));
      chk($sformatf("sweep_lat%0d_men", lat[g]), 32'(nen[g]), 32'd1);
      chk($sformatf("sweep_lat%0d_rdata", lat[g]), 32'(rd[g]), 32'h1234);
    end
  endtask

  // Transaction-level reference: arbiter free at sampling edges, round robin,
  // grant on the next cycle, response after a fixed delay, flat memory array
  bit          e_fg [c_n_rand+8];
  bit          e_dg [c_n_rand+8];
  bit          e_men[c_n_rand+8];
  bit          e_mwe[c_n_rand+8];
  bit          e_fv [c_n_rand+8];
  bit          e_da [c_n_rand+8];
  bit          e_rdc[c_n_rand+8];
  logic [15:0] e_maddr[c_n_rand+8];
  logic [15:0] e_mwd  [c_n_rand+8];
  logic [15:0] e_rd   [c_n_rand+8];
  bit   [15:0] rmem [65536];
  bit          rwr  [65536];

  task automatic rand_test();
    int          nxt;
    int          r;
    bit          last_d, wd, wwe, gf, gd, bad;
    logic [15:0] a;
    nxt = 0; last_d = 1'b0;
    do_reset();
    for (int e = 0; e < c_n_rand; e++) begin
      tick();
      gf = 1'b0; gd = 1'b0;
      if (e == nxt) begin
        if (f_req || d_req) begin
          wd  = d_req && (!f_req || !last_d);
          last_d = wd;
          wwe = wd && d_we;
          a   = wd ? d_addr : f_addr;
          gf  = !wd; gd = wd;
          e_fg[e] = !wd; e_dg[e] = wd; e_men[e] = 1'b1; e_mwe[e] = wwe;
          e_maddr[e] = a; e_mwd[e] = d_wdata;
          if (wwe) begin
            rmem[a] = d_wdata; rwr[a] = 1'b1;
            e_da[e+1] = 1'b1;
            nxt = e + 2;
          end else begin
            r = e + c_lat0 + 1;
            e_rd[r]  = rwr[a] ? rmem[a] : hashf(a);
            e_rdc[r] = 1'b1;
            if (wd) e_da[r] = 1'b1; else e_fv[r] = 1'b1;
            nxt = r + 1;
          end
        end else begin
          nxt = e + 1;
        end
      end
      bad = (fg_v[0] !== e_fg[e]) || (dg_v[0] !== e_dg[e]) || (men_v[0] !== e_men[e]) ||
            (fv_v[0] !== e_fv[e]) || (da_v[0] !== e_da[e]) ||
            (e_men[e] && ((mwe_v[0] !== e_mwe[e]) || (maddr_v[0] !== e_maddr[e]) ||
                          (e_mwe[e] && (mwd_v[0] !== e_mwd[e])))) ||
            (e_rdc[e] && ((e_fv[e] && (frd_v[0] !== e_rd[e])) ||
                          (e_da[e] && (drd_v[0] !== e_rd[e]))));
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got fg=%b dg=%b men=%b we=%b addr=%h wd=%h rv=%b ack=%b frd=%h drd=%h; expected fg=%b dg=%b men=%b we=%b addr=%h wd=%h rv=%b ack=%b rd=%h",
                 e, fg_v[0], dg_v[0], men_v[0], mwe_v[0], maddr_v[0], mwd_v[0], fv_v[0], da_v[0],
                 frd_v[0], drd_v[0], e_fg[e], e_dg[e], e_men[e], e_mwe[e], e_maddr[e], e_mwd[e],
                 e_fv[e], e_da[e], e_rd[e]);
      end
      if (gf) f_req = 1'b0;
      if (gd) d_req = 1'b0;
      if (!f_req && $urandom_range(0, 2) == 0) begin
        f_req = 1'b1; f_addr = 16'($urandom_range(0, 63));
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 63)); d_wdata = 16'($urandom);
      end
    end
    f_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    // fr dr dwe   fa        da        dwd       exp_d cyc chk rd
    vt[0] = '{1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 4, 1, 16'h8123};
    vt[1] = '{0, 1, 1, 16'h0000, 16'h00A0, 16'hBEEF, 1, 2, 0, 16'h0000};
    vt[2] = '{0, 1, 0, 16'h0000, 16'h00A0, 16'h0000, 1, 4, 1, 16'hBEEF};
    vt[3] = '{1, 1, 0, 16'h0011, 16'h00A0, 16'h0000, 0, 4, 1, 16'h8122};
    vt[4] = '{1, 1, 1, 16'h0010, 16'h00B0, 16'h1357, 0, 4, 1, 16'h8123};
    vt[5] = '{0, 1, 0, 16'h0000, 16'h00B0, 16'h0000, 1, 4, 1, 16'h1357};
    vt[6] = '{1, 0, 0, 16'h0020, 16'h0000, 16'h0000, 0, 4, 1, 16'h8113};
    vt[7] = '{1, 1, 0, 16'h0010, 16'h00B0, 16'h0000, 1, 4, 1, 16'h1357};
    vt[8] = '{0, 1, 1, 16'h0000, 16'h00C0, 16'h0F0F, 1, 2, 0, 16'h0000};

    do_reset();
    chk("reset_outputs_zero",
        {fg_v[0], dg_v[0], fv_v[0], da_v[0], men_v[0], mwe_v[0], frd_v[0] | drd_v[0] | maddr_v[0] | mwd_v[0]},
        32'd0);
    for (int i = 0; i < 9; i++) run_vec(i);
    repeat (4) tick();
    rr_test();
    reset_mid_test();
    sweep_test();
    rand_test();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/sik_mem_arbiter.md
# sik_mem_arbiter

Single-port memory arbiter for the Sik stack processor. It shares one 16-bit-word synchronous memory between two requesters: the instruction-fetch path (port F, read-only) and the data path for Load/Store (port D, read/write). It sequences each access through a fixed-latency memory with one transaction outstanding. Simultaneous requests are resolved round-robin.

## Interface
Parameters:
- ADDR_W, 16, address width (word addresses)
- DATA_W, 16, word width
- MEM_LAT, 2, memory read latency in cycles; legal range 1..4

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch request accepted (one-cycle pulse)
- f_rvalid  out  1  fetch read data valid (one-cycle pulse)
- f_rdata  out  DATA_W  fetch read data, qualified by f_rvalid
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted (one-cycle pulse)
- d_ack  out  1  data access complete; for loads, d_rdata is valid
- d_rdata  out  DATA_W  load data, qualified by d_ack
- m_en  out  1  memory enable
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after the m_en cycle

## Operation
- FSM states:
  - IDLE: no transaction; samples requests.
  - ISSUE: drives memory for exactly one cycle.
  - WAIT: reads only; counts down MEM_LAT cycles.
  - RESP: drives response for one cycle and samples requests.
- Transitions:
  - IDLE/RESP → ISSUE if f_req or d_req is sampled high; otherwise → IDLE.
  - ISSUE → WAIT for a read; ISSUE → RESP for a write.
  - WAIT → RESP when the count reaches 0.
- Arbitration, evaluated only in IDLE and RESP:
  - If only one port requests, that port wins.
  - If both request, the port not granted last wins.
  - last_gnt resets to F, so D wins the first tie.
  - last_gnt updates on every grant.
- The winner's command (port id, we, addr, wdata) is registered at the sampling edge. Fetch is always a read.
- ISSUE cycle: m_en=1; m_we, m_addr, m_wdata come from the registered command; the winner's gnt=1.
- WAIT cycle count:
  - 3-bit down-counter loaded with MEM_LAT-1 on entry to WAIT.
  - m_rdata is captured into the shared read-data register at the end of the last WAIT cycle.
- RESP cycle:
  - The winner's f_rvalid or d_ack is 1.
  - f_rdata and d_rdata both carry the captured register.
  - The register holds its value until the next capture.
- Requester rule:
  - Hold req, addr, we and wdata stable from assertion through the gnt cycle.
  - Deassert req after gnt unless a new access is wanted.
  - The arbiter ignores req during ISSUE and WAIT.
- All memory-facing and handshake outputs are registered (no combinational in→out paths).

## Timing
- Reset values: all outputs 0; state IDLE; last_gnt=F; counter 0; read-data register 0.
- Read, with req first sampled at edge 0:
  - gnt and m_en in cycle 1.
  - WAIT in cycles 2..MEM_LAT+1.
  - rvalid in cycle MEM_LAT+2.
- Write: gnt, m_en and m_we in cycle 1; d_ack in cycle 2.
- Back-to-back: a request sampled in RESP enters ISSUE the next cycle with no IDLE bubble.
  - Read throughput: one per MEM_LAT+2 cycles.
  - Write throughput: one per 2 cycles.
- Simultaneous F and D requests are resolved round-robin. With both held continuously, grants alternate D,F,D,F…
- Reset mid-transaction (ISSUE, WAIT or RESP): the next cycle is IDLE with all outputs 0.
  - No rvalid or ack is ever produced for the aborted access.
  - The requester must reissue.
  - A write whose ISSUE cycle completed before reset stays in memory.
- Requests held high during reset are sampled on the first IDLE edge after reset deasserts.

## Test plan
- MEM_LAT=2, mem[0x0010]=0x8123, f_req/f_addr=0x0010 sampled at edge 0 → cycle 1: f_gnt=1, m_en=1, m_we=0, m_addr=0x0010; cycle 4: f_rvalid=1, f_rdata=0x8123; no other pulses.
- d_req, d_we=1, d_addr=0x00A0, d_wdata=0xBEEF → cycle 1: d_gnt=1, m_we=1, m_wdata=0xBEEF; cycle 2: d_ack=1. A following load from 0x00A0 → d_ack with d_rdata=0xBEEF.
- After reset, f_req and d_req held high together for 8 transactions → grant order D,F,D,F,D,F,D,F; no bubble cycles between RESP and ISSUE.
- Reset asserted in the first WAIT cycle of a fetch → next cycle all outputs 0, state IDLE; f_rvalid never asserts; a subsequent tie grants D.
- Sweep MEM_LAT=1 and 4 with reads of 0x1234 → rvalid exactly 3 and 6 cycles after the sampling edge; m_en high for exactly 1 cycle per access.
